pc_stack: RTL and testbench
===========================

PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the program-counter and data width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter DEPTH, default 8, meaning the number of return-address stack entries (power of 2, DEPTH >= 2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port clr, input, 1, synchronous clear request.
REQ-006 SHALL have port load, input, 1, load out from din.
REQ-007 SHALL have port inc, input, 1, increment out by 1.
REQ-008 SHALL have port call, input, 1, push out+1 and jump to din.
REQ-009 SHALL have port ret, input, 1, pop the stack top into out.
REQ-010 SHALL have port din, input, WIDTH, jump/load target.
REQ-011 SHALL have port out, output, WIDTH, registered program counter.
REQ-012 SHALL have port top, output, WIDTH, current stack top (combinational; all-zero when empty).
REQ-013 SHALL have port count, output, $clog2(DEPTH+1), number of valid stack entries.
REQ-014 SHALL have ports full and empty, output, 1 each, combinational decodes of count (count==DEPTH, count==0).
REQ-015 SHALL have port wrap, output, 1, registered one-cycle pulse on an increment from all-ones.
REQ-016 SHALL have ports ovf and unf, output, 1 each, sticky overflow/underflow error flags.

Function
REQ-017 SHALL apply exactly one operation per cycle with fixed priority: clr > ret > call > load > inc > hold.
REQ-018 clr SHALL set out=0, count=0, wrap=0, ovf=0, unf=0 on the next edge.
REQ-019 ret with count>0 SHALL set out=top and decrement count; latency one cycle.
REQ-020 ret with count==0 SHALL leave out and count unchanged and set unf=1.
REQ-021 call with count<DEPTH SHALL write (out+1) mod 2^WIDTH to entry count, increment count, and set out=din.
REQ-022 call with count==DEPTH SHALL leave out, count and stack contents unchanged and set ovf=1.
REQ-023 load SHALL set out=din; stack unaffected.
REQ-024 inc SHALL set out=(out+1) mod 2^WIDTH; wrap SHALL be 1 for the cycle after out goes from all-ones to 0, else 0.
REQ-025 When no operation is asserted, out, count and flags SHALL hold, and wrap SHALL be 0.
REQ-026 Simultaneous call and ret SHALL perform ret only; the call is discarded without setting ovf.
REQ-027 ovf and unf SHALL remain set until clr or reset.
REQ-028 Stack entries above count SHALL be don't-care and SHALL NOT affect top.

Reset
REQ-029 rst_n low SHALL immediately force out=0, count=0, wrap=0, ovf=0, unf=0, regardless of clk.
REQ-030 Stack storage array SHALL NOT require reset; count=0 makes it invalid.
REQ-031 Deassertion of rst_n SHALL be honoured from the first rising clk edge after deassertion; an operation in progress when rst_n falls is discarded.

Structure
REQ-032 A shared package pc_pkg SHALL hold the operation-select enum (OP_CLR, OP_RET, OP_CALL, OP_LOAD, OP_INC, OP_HOLD) and the default WIDTH/DEPTH constants.
REQ-033 Priority decode SHALL be a single combinational block producing one pc_pkg operation value.
REQ-034 The stack SHALL be a sub-module lifo_stack (WIDTH, DEPTH; push, pop, wdata, top, count, full, empty) with rst_n clearing count only.

Verification
REQ-035 Reset/inc: rst_n=0 then release, inc=1 for 3 cycles -> out=0,1,2,3; flags 0.
REQ-036 Wrap: load din=16'hFFFF, then inc -> out=0, wrap=1 for exactly one cycle, then 0.
REQ-037 Call/ret: out=16'h0010, call din=16'h0100 -> out=0x0100, count=1, top=0x0011; ret -> out=0x0011, count=0, empty=1.
REQ-038 Overflow: 8 calls with DEPTH=8 -> full=1; ninth call -> out, count unchanged, ovf=1 sticky until clr.
REQ-039 Underflow and priority: ret when empty -> unf=1, out held; call+ret+load same cycle with count=1 -> only ret takes effect.
REQ-040 Async reset mid-operation: rst_n pulsed low between edges while count=3 -> out=0, count=0 immediately, before any clk edge.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: constants and types shared by the program-counter stack.
//   DEF_WIDTH / DEF_DEPTH : default PC width and return-stack depth
//   op_e                  : the single operation applied in a cycle,
//                           listed in priority order
package pc_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;

    typedef enum logic [2:0] {
        OP_CLR  = 3'd0,
        OP_RET  = 3'd1,
        OP_CALL = 3'd2,
        OP_LOAD = 3'd3,
        OP_INC  = 3'd4,
        OP_HOLD = 3'd5
    } op_e;

endpackage

// File: rtl/lifo_stack.sv
// lifo_stack: return-address LIFO for pc_stack.
//   clk, rst_n : clock, asynchronous active-low reset (clears count only)
//   clr        : synchronous clear of count
//   push/wdata : write wdata at entry count and grow by one (ignored when full)
//   pop        : shrink by one (ignored when empty)
//   top        : newest valid entry, all-zero when empty
//   count      : number of valid entries; full/empty decode it
module lifo_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr && !push;

    // DEPTH is a power of two, so the low bits of count address the next free
    // slot, and subtracting one modulo DEPTH addresses the newest entry even
    // when count == DEPTH.
    assign wr_idx  = count[AW-1:0];
    assign top_idx = wr_idx - IDX_ONE;
    assign top     = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (do_push) begin
            count <= count + CNT_ONE;
        end else if (do_pop) begin
            count <= count - CNT_ONE;
        end
    end

    // Storage is never reset: entries at or above count are invalid anyway.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/pc_stack.sv
// pc_stack: program counter with a return-address stack.
//   clk, rst_n        : clock, asynchronous active-low reset
//   clr               : synchronous clear of PC, stack and flags
//   ret / call / load / inc : operations, priority clr > ret > call > load > inc
//   din               : call / load target
//   out               : registered program counter
//   top, count        : stack top (zero when empty) and entry count
//   full, empty       : decodes of count
//   wrap              : one-cycle pulse after an increment from all-ones
//   ovf, unf          : sticky call-when-full / ret-when-empty flags
module pc_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       load,
    input  logic                       inc,
    input  logic                       call,
    input  logic                       ret,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           out,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       wrap,
    output logic                       ovf,
    output logic                       unf
);

    localparam logic [WIDTH-1:0] PC_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    op_e              op;
    logic [WIDTH-1:0] pc_next;

    always_comb begin
        op = OP_HOLD;
        if (clr)       op = OP_CLR;
        else if (ret)  op = OP_RET;
        else if (call) op = OP_CALL;
        else if (load) op = OP_LOAD;
        else if (inc)  op = OP_INC;
    end

    assign pc_next = out + PC_ONE;

    lifo_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (op == OP_CLR),
        .push  (op == OP_CALL),
        .pop   (op == OP_RET),
        .wdata (pc_next),
        .top   (top),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out  <= '0;
            wrap <= 1'b0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (op)
                OP_CLR: begin
                    out <= '0;
                    ovf <= 1'b0;
                    unf <= 1'b0;
                end
                OP_RET: begin
                    if (empty) unf <= 1'b1;
                    else       out <= top;
                end
                OP_CALL: begin
                    if (full) ovf <= 1'b1;
                    else      out <= din;
                end
                OP_LOAD: out <= din;
                OP_INC: begin
                    out  <= pc_next;
                    wrap <= &out;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: directed and randomized checks of pc_stack against a
// queue-based reference model.
module tb_pc_stack;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int CW = $clog2(D+1);

    logic          clk = 1'b0;
    logic          rst_n, clr, load, inc, call, ret;
    logic [W-1:0]  din, out, top;
    logic [CW-1:0] count;
    logic          full, empty, wrap, ovf, unf;

    pc_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .inc(inc),
        .call(call), .ret(ret), .din(din), .out(out), .top(top),
        .count(count), .full(full), .empty(empty), .wrap(wrap),
        .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    // reference model
    logic [W-1:0] m_out;
    logic [W-1:0] m_q[$];
    logic         m_wrap, m_ovf, m_unf;
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic model_reset();
        m_out = '0;
        m_q.delete();
        m_wrap = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    // Drive one cycle of inputs, let an edge happen, update the model, and
    // return #1 after the edge so outputs are sampled away from it.
    task automatic step(input logic s_clr, input logic s_ret, input logic s_call,
                        input logic s_load, input logic s_inc, input logic [W-1:0] s_din);
        clr = s_clr; ret = s_ret; call = s_call; load = s_load; inc = s_inc; din = s_din;
        @(posedge clk);
        m_wrap = 1'b0;
        if (s_clr) begin
            m_out = '0; m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else if (s_ret) begin
            if (m_q.size() == 0) m_unf = 1'b1;
            else                 m_out = m_q.pop_back();
        end else if (s_call) begin
            if (m_q.size() == D) m_ovf = 1'b1;
            else begin
                m_q.push_back(W'((int'(m_out) + 1) % 65536));
                m_out = s_din;
            end
        end else if (s_load) begin
            m_out = s_din;
        end else if (s_inc) begin
            m_wrap = (m_out == 16'hFFFF);
            m_out  = W'((int'(m_out) + 1) % 65536);
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, '0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 0; ret = 0; call = 0; load = 0; inc = 0; din = '0;
        model_reset();
        #12;
        n_tests++; if (out !== 16'h0000) begin n_fail++; $display("FAIL reset_out got=%h want=0000", out); end
        n_tests++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", count); end
        n_tests++; if ({empty, full, wrap, ovf, unf} !== 5'b10000) begin
            n_fail++; $display("FAIL reset_flags got=%b want=10000 (empty,full,wrap,ovf,unf)", {empty, full, wrap, ovf, unf});
        end
        n_tests++; if (top !== 16'h0000) begin n_fail++; $display("FAIL reset_top got=%h want=0000", top); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_inc();
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 0, 0, 1, '0);
            n_tests++; if (out !== W'(i)) begin n_fail++; $display("FAIL inc_out got=%h want=%h", out, W'(i)); end
            n_tests++; if ({wrap, ovf, unf} !== 3'b000) begin n_fail++; $display("FAIL inc_flags got=%b want=000", {wrap, ovf, unf}); end
        end
    endtask

    task automatic test_wrap();
        step(0, 0, 0, 1, 0, 16'hFFFF);
        n_tests++; if (out !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_load got=%h want=ffff", out); end
        step(0, 0, 0, 0, 1, '0);
        n_tests++; if (out !== 16'h0000) begin n_fail++; $display("FAIL wrap_out got=%h want=0000", out); end
        n_tests++; if (wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_pulse got=%b want=1", wrap); end
        idle();
        n_tests++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_clear got=%b want=0", wrap); end
        step(0, 0, 0, 0, 1, '0);
        n_tests++; if (wrap !== 1'b0 || out !== 16'h0001) begin
            n_fail++; $display("FAIL wrap_noinc got=%b/%h want=0/0001", wrap, out);
        end
    endtask

    task automatic test_call_ret();
        step(0, 0, 0, 1, 0, 16'h0010);
        step(0, 0, 1, 0, 0, 16'h0100);
        n_tests++; if (out !== 16'h0100) begin n_fail++; $display("FAIL call_out got=%h want=0100", out); end
        n_tests++; if (count !== 4'd1) begin n_fail++; $display("FAIL call_count got=%0d want=1", count); end
        n_tests++; if (top !== 16'h0011) begin n_fail++; $display("FAIL call_top got=%h want=0011", top); end
        step(0, 1, 0, 0, 0, '0);
        n_tests++; if (out !== 16'h0011) begin n_fail++; $display("FAIL ret_out got=%h want=0011", out); end
        n_tests++; if (count !== 4'd0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL ret_count got=%0d/%b want=0/1", count, empty);
        end
    endtask

    task automatic test_overflow();
        step(1, 0, 0, 0, 0, '0);
        for (int i = 0; i < D; i++) step(0, 0, 1, 0, 0, W'(16'h1000 + i * 16'h0100));
        n_tests++; if (full !== 1'b1 || count !== 4'd8) begin
            n_fail++; $display("FAIL ovf_full got=%b/%0d want=1/8", full, count);
        end
        n_tests++; if (top !== 16'h1601) begin n_fail++; $display("FAIL ovf_top got=%h want=1601", top); end
        step(0, 0, 1, 0, 0, 16'hBEEF);
        n_tests++; if (out !== 16'h1700 || count !== 4'd8) begin
            n_fail++; $display("FAIL ovf_hold got=%h/%0d want=1700/8", out, count);
        end
        n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b want=1", ovf); end
        step(0, 1, 0, 0, 0, '0);
        n_tests++; if (out !== 16'h1601 || ovf !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sticky got=%h/%b want=1601/1", out, ovf);
        end
        step(1, 0, 0, 0, 0, '0);
        n_tests++; if (ovf !== 1'b0 || count !== 4'd0 || out !== 16'h0000) begin
            n_fail++; $display("FAIL ovf_clr got=%b/%0d/%h want=0/0/0000", ovf, count, out);
        end
    endtask

    task automatic test_underflow_priority();
        step(0, 0, 0, 1, 0, 16'h0042);
        step(0, 1, 0, 0, 0, '0);
        n_tests++; if (unf !== 1'b1 || out !== 16'h0042 || count !== 4'd0) begin
            n_fail++; $display("FAIL unf_set got=%b/%h/%0d want=1/0042/0", unf, out, count);
        end
        step(0, 0, 1, 0, 0, 16'h0200);
        step(0, 1, 1, 1, 1, 16'h0777);
        n_tests++; if (out !== 16'h0043 || count !== 4'd0) begin
            n_fail++; $display("FAIL prio_ret got=%h/%0d want=0043/0", out, count);
        end
        n_tests++; if (ovf !== 1'b0 || unf !== 1'b1) begin
            n_fail++; $display("FAIL prio_flags got=%b/%b want=0/1", ovf, unf);
        end
        step(0, 1, 1, 0, 0, 16'h0300);
        n_tests++; if (count !== 4'd0 || out !== 16'h0043) begin
            n_fail++; $display("FAIL prio_callret_empty got=%0d/%h want=0/0043", count, out);
        end
        step(1, 0, 0, 0, 0, '0);
    endtask

    task automatic test_async_reset();
        step(0, 0, 0, 1, 0, 16'h0500);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, W'(16'h0600 + i));
        n_tests++; if (count !== 4'd3) begin n_fail++; $display("FAIL async_pre got=%0d want=3", count); end
        clr = 0; ret = 0; call = 1; load = 0; inc = 1; din = 16'h0ABC;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++; if (out !== 16'h0000 || count !== 4'd0) begin
            n_fail++; $display("FAIL async_now got=%h/%0d want=0000/0", out, count);
        end
        n_tests++; if (empty !== 1'b1 || top !== 16'h0000) begin
            n_fail++; $display("FAIL async_empty got=%b/%h want=1/0000", empty, top);
        end
        @(posedge clk); #1;
        n_tests++; if (out !== 16'h0000 || count !== 4'd0) begin
            n_fail++; $display("FAIL async_held got=%h/%0d want=0000/0", out, count);
        end
        call = 0; inc = 0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        step(0, 0, 0, 0, 1, '0);
        n_tests++; if (out !== 16'h0001) begin n_fail++; $display("FAIL async_release got=%h want=0001", out); end
    endtask

    task automatic test_random();
        logic [W-1:0] m_top;
        step(1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 400; i++) begin
            logic r_clr, r_ret, r_call, r_load, r_inc;
            r_clr  = ($urandom_range(0, 99) < 3);
            r_ret  = ($urandom_range(0, 99) < 25);
            r_call = ($urandom_range(0, 99) < 35);
            r_load = ($urandom_range(0, 99) < 15);
            r_inc  = ($urandom_range(0, 99) < 50);
            step(r_clr, r_ret, r_call, r_load, r_inc,
                 ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom_range(0, 65535)));
            m_top = (m_q.size() > 0) ? m_q[$] : '0;
            n_tests++; if (out !== m_out) begin n_fail++; $display("FAIL rnd_out cyc=%0d got=%h want=%h", i, out, m_out); end
            n_tests++; if (count !== CW'(m_q.size())) begin n_fail++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", i, count, m_q.size()); end
            n_tests++; if (top !== m_top) begin n_fail++; $display("FAIL rnd_top cyc=%0d got=%h want=%h", i, top, m_top); end
            n_tests++; if (full !== (m_q.size() == D) || empty !== (m_q.size() == 0)) begin
                n_fail++; $display("FAIL rnd_fullempty cyc=%0d got=%b%b size=%0d", i, full, empty, m_q.size());
            end
            n_tests++; if ({wrap, ovf, unf} !== {m_wrap, m_ovf, m_unf}) begin
                n_fail++; $display("FAIL rnd_flags cyc=%0d got=%b want=%b", i, {wrap, ovf, unf}, {m_wrap, m_ovf, m_unf});
            end
        end
    endtask

    initial begin
        test_reset();
        test_inc();
        test_wrap();
        test_call_ret();
        test_overflow();
        test_underflow_priority();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
